fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Upstream neighbour of instruction_memory. Owns the program counter and drives instruction_memory's read_address.
- Each cycle selects the next PC from sequential, branch and JALR sources. Detects misaligned and out-of-range targets.
- Provides a one-cycle boot hold after reset, a sticky halt state and a 64-bit retired-instruction counter for the RV32I single-cycle core.

Parameters:
- XLEN, 32, datapath/address width.
- DEPTH, 32, instruction memory depth in 32-bit words; valid PC range is 0 .. DEPTH*4-4.
- RESET_VECTOR, 0, PC value loaded on reset; must be word-aligned and in range.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- stall  input  1  hold PC and counter this cycle
- branch_taken  input  1  conditional branch / JAL taken
- branch_target  input  XLEN  PC-relative target from ALU
- jalr_taken  input  1  JALR executing
- jalr_target  input  XLEN  rs1+imm; bit 0 cleared internally
- halt_req  input  1  EBREAK/ECALL decoded; halt after retire
- pc  output  XLEN  current PC, to instruction_memory read_address
- pc_plus4  output  XLEN  pc+4 (combinational, mod 2^XLEN), for JAL/JALR link
- fetch_valid  output  1  instruction at pc is to be executed
- misaligned  output  1  sticky: target had bit 1 set
- out_of_range  output  1  sticky: target >= DEPTH*4
- halted  output  1  state == HALTED
- instret  output  64  retired instruction count

Behaviour:
- Reset (rst_n low at posedge): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, out_of_range=0, halted=0, instret=0. Applies identically mid-operation from any state.
- States:
  - BOOT: fetch_valid=0, pc held; next cycle -> RUN unconditionally. Gives instruction_memory one cycle of settled address.
  - RUN: fetch_valid=1.
  - HALTED: fetch_valid=0, halted=1, pc and instret frozen, all inputs ignored; exit only via reset.
- RUN, stall=1: pc, instret and state hold. branch_taken, jalr_taken and halt_req are ignored that cycle.
- RUN, stall=0:
  - Target selection, priority jalr > branch > sequential:
    - jalr_taken: target = jalr_target & ~1.
    - else branch_taken: target = branch_target.
    - else target = pc_plus4.
  - Fault checks on target:
    - If target[1]=1: misaligned<=1, state<=HALTED, pc unchanged, instret unchanged (faulting jump does not retire).
    - Else if target >= DEPTH*4 (unsigned): out_of_range<=1, state<=HALTED, pc unchanged, instret unchanged.
    - Both faults present: only misaligned is set.
  - No fault: pc<=target, instret<=instret+1.
  - halt_req with no fault: retire normally (pc<=target, instret+1), then state<=HALTED.
  - Fault and halt_req together: fault flag set, instret unchanged.
- Sequential wrap: pc_plus4 wraps at 2^XLEN, but out_of_range catches it first because DEPTH*4 < 2^XLEN.
- instret wraps from 2^64-1 to 0 with no flag.
- Latency: next-PC decision is combinational on the current inputs; pc updates at the next posedge (1 cycle).

Decomposition:
- Shared header rv32i_defines.vh:
  - XLEN default
  - state encodings FETCH_BOOT=2'd0, FETCH_RUN=2'd1, FETCH_HALTED=2'd2
  - RESET_VECTOR default
- One sub-module, next_pc_sel: combinational priority mux, bit-0 clear, misaligned and range checks.
- The top holds the FSM, the pc register and the instret counter.

Test Plan:
1. Reset then free-run with DEPTH=32: pc=0 and fetch_valid=0 in the first cycle after reset release; then pc=0,4,8,… one step per cycle; instret=3 after three RUN cycles.
2. At pc=0x10, assert stall for 2 cycles together with branch_taken=1 and branch_target=0x40: pc holds 0x10 and the branch is ignored. Release stall with branch_taken=1 and target=0x40: pc=0x40 next cycle.
3. Same cycle, jalr_taken=1 with jalr_target=0x21 and branch_taken=1 with branch_target=0x08: pc=0x20 (JALR wins, bit 0 cleared), instret increments.
4. branch_target=0x12: misaligned=1, halted=1, pc stays at its old value, instret unchanged; later branch inputs have no effect.
5. At pc=0x7C (last word), sequential step: out_of_range=1, halted=1, pc stays 0x7C.
6. halt_req at pc=0x08: pc=0x0C, instret+1, then halted=1 and fetch_valid=0. Reset mid-halt: all outputs return to reset values, BOOT for 1 cycle, then pc=0 in RUN.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared defaults, fetch state encodings and the fault record for the RV32I fetch PC unit.
package fetch_pc_unit_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] FETCH_BOOT   = 2'd0;
  localparam logic [1:0] FETCH_RUN    = 2'd1;
  localparam logic [1:0] FETCH_HALTED = 2'd2;

  typedef struct packed {
    logic misaligned;
    logic out_of_range;
  } fault_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Next-PC priority mux (jalr > branch > sequential) with alignment and range checks.
// Purely combinational; misaligned masks out_of_range when both apply.
module next_pc_sel
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 32
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] target,
  output fault_t          fault
);

  // One extra bit so DEPTH*4 == 2^XLEN would still compare correctly.
  localparam logic [XLEN:0] LIMIT = (XLEN+1)'(DEPTH * 4);

  always_comb begin
    target = pc_plus4;
    if (jalr_taken) begin
      target = {jalr_target[XLEN-1:1], 1'b0};
    end else if (branch_taken) begin
      target = branch_target;
    end
    fault.misaligned   = target[1];
    fault.out_of_range = !target[1] && ({1'b0, target} >= LIMIT);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, boot/run/halted FSM and retired-instruction counter; pc updates one cycle after the decision.
// stall freezes pc, instret and state; a fault or retired halt_req parks the unit until reset.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              DEPTH        = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic            out_of_range,
  output logic            halted,
  output logic [63:0]     instret
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [63:0]     instret_q, instret_d;
  logic            misaligned_q, misaligned_d;
  logic            out_of_range_q, out_of_range_d;
  logic [XLEN-1:0] target;
  fault_t          fault;

  assign pc_plus4 = pc_q + XLEN'(4);

  next_pc_sel #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_next_pc_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jalr_taken    (jalr_taken),
    .jalr_target   (jalr_target),
    .target        (target),
    .fault         (fault)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instret_d      = instret_q;
    misaligned_d   = misaligned_q;
    out_of_range_d = out_of_range_q;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (!stall) begin
          // A faulting jump neither moves pc nor retires.
          if (fault.misaligned || fault.out_of_range) begin
            misaligned_d   = misaligned_q   | fault.misaligned;
            out_of_range_d = out_of_range_q | fault.out_of_range;
            state_d        = FETCH_HALTED;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 64'd1;
            if (halt_req) state_d = FETCH_HALTED;
          end
        end
      end
      FETCH_HALTED: state_d = FETCH_HALTED;
      default:      state_d = FETCH_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= FETCH_BOOT;
      pc_q           <= RESET_VECTOR;
      instret_q      <= 64'd0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instret_q      <= instret_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = (state_q == FETCH_RUN);
  assign halted       = (state_q == FETCH_HALTED);
  assign misaligned   = misaligned_q;
  assign out_of_range = out_of_range_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then randomized traffic against a behavioural model.
module tb_fetch_pc_unit;

  localparam int DEPTH = 32;
  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jalr_taken = 1'b0;
  logic [31:0] jalr_target = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, misaligned, out_of_range, halted;
  logic [63:0] instret;

  fetch_pc_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jalr_taken(jalr_taken), .jalr_target(jalr_target),
    .halt_req(halt_req), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .misaligned(misaligned),
    .out_of_range(out_of_range), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        oor;
    logic        hlt;
    longint unsigned ir;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: what the architecture says happens, not how.
  longint unsigned m_pc, m_ir;
  bit m_boot, m_halt, m_mis, m_oor;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit bt, input logic [31:0] btg,
                      input bit jt, input logic [31:0] jtg, input bit hr);
    longint unsigned tgt;
    exp_t e;
    rst_n = rst; stall = st; branch_taken = bt; branch_target = btg;
    jalr_taken = jt; jalr_target = jtg; halt_req = hr;
    if (!rst) begin
      m_pc = RV; m_ir = 0; m_boot = 1; m_halt = 0; m_mis = 0; m_oor = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt && !st) begin
      if (jt)      tgt = longint'(jtg) - (jtg % 2);
      else if (bt) tgt = btg;
      else         tgt = (m_pc + 4) % 64'h1_0000_0000;
      if ((tgt / 2) % 2 == 1) begin
        m_mis = 1; m_halt = 1;
      end else if (tgt >= DEPTH * 4) begin
        m_oor = 1; m_halt = 1;
      end else begin
        m_pc = tgt; m_ir = m_ir + 1;
        if (hr) m_halt = 1;
      end
    end
    e.pc = m_pc[31:0]; e.fv = !m_boot && !m_halt; e.mis = m_mis; e.oor = m_oor;
    e.hlt = m_halt; e.ir = m_ir;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, (longint'(e.pc) + 4) % 64'h1_0000_0000);
        check("fetch_valid", fetch_valid, e.fv);
        check("misaligned", misaligned, e.mis);
        check("out_of_range", out_of_range, e.oor);
        check("halted", halted, e.hlt);
        check("instret", instret, e.ir);
      end
    end
  end

  initial begin : driver
    logic [31:0] t;
    bit rs, st, bt, jt, hr;
    logic [31:0] btg, jtg;
    // Reset, boot, free-run
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (4) idle();
    // Stall ignores a pending branch, then the branch lands
    repeat (2) step(1, 1, 1, 32'h40, 0, 0, 0);
    step(1, 0, 1, 32'h40, 0, 0, 0);
    // JALR beats branch and has bit 0 cleared
    step(1, 0, 1, 32'h08, 1, 32'h21, 0);
    // Misaligned branch halts; later branches are ignored
    step(1, 0, 1, 32'h12, 0, 0, 0);
    step(1, 0, 1, 32'h08, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h10, 1);
    // Last word then sequential runs off the end
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 1, 32'h7C, 0, 0, 0);
    idle();
    idle();
    // Both faults at once flag only misaligned
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    // Halt request retires then halts; reset mid-halt recovers
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 1, 32'h08, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // Stalled halt_req is ignored
    step(1, 1, 0, 0, 0, 0, 1);
    idle();
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0);
      bt = ($urandom_range(0, 2) == 0);
      jt = ($urandom_range(0, 5) == 0);
      hr = ($urandom_range(0, 39) == 0);
      t = $urandom_range(0, DEPTH - 1);
      btg = ($urandom_range(0, 9) == 0) ? $urandom : (t << 2);
      t = $urandom_range(0, DEPTH - 1);
      jtg = ($urandom_range(0, 9) == 0) ? $urandom : ((t << 2) | 32'($urandom_range(0, 1)));
      step(!rs, st, bt, btg, jt, jtg, hr);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
